// File: rtl/jam_pkg.sv
// Shared constants, FSM state encoding and the permutation field helper for
// the job-assignment cost sequencer.
package jam_pkg;

    localparam int N      = 8;
    localparam int IDX_W  = 3;
    localparam int COST_W = 7;
    localparam int SUM_W  = 10;
    localparam int CNT_W  = 4;

    localparam logic [SUM_W-1:0] MIN_INIT  = 10'h3FF;
    localparam logic [CNT_W-1:0] MATCH_MAX = 4'd15;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        DRAIN  = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } jam_state_e;

    // Job assigned to worker k: the 3-bit field at bits [3k+2:3k].
    function automatic logic [IDX_W-1:0] job_of(input logic [N*IDX_W-1:0] perm,
                                                input logic [IDX_W-1:0]   k);
        return perm[int'(k)*IDX_W +: IDX_W];
    endfunction

endpackage

// File: rtl/jam_min_tracker.sv
// Running minimum / match-count tracker; the first update after reset or after
// a completed run compares against a fresh MIN_INIT/0 baseline.
module jam_min_tracker
    import jam_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             update_i,
    input  logic             last_i,
    input  logic [SUM_W-1:0] sum_i,
    output logic [SUM_W-1:0] min_o,
    output logic [CNT_W-1:0] count_o,
    output logic             init_pending_o
);

    logic [SUM_W-1:0] min_q;
    logic [CNT_W-1:0] count_q;
    logic             pending_q;
    logic [SUM_W-1:0] base_min;
    logic [CNT_W-1:0] base_cnt;

    assign base_min = pending_q ? MIN_INIT : min_q;
    assign base_cnt = pending_q ? '0 : count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            min_q     <= '0;
            count_q   <= '0;
            pending_q <= 1'b1;
        end else if (update_i) begin
            // The update that closes a run re-arms the baseline for the next run.
            pending_q <= last_i;
            if (sum_i < base_min) begin
                min_q   <= sum_i;
                count_q <= CNT_W'(1);
            end else if (sum_i == base_min) begin
                min_q   <= base_min;
                count_q <= (base_cnt == MATCH_MAX) ? MATCH_MAX : base_cnt + CNT_W'(1);
            end else begin
                min_q   <= base_min;
                count_q <= base_cnt;
            end
        end
    end

    assign min_o          = min_q;
    assign count_o        = count_q;
    assign init_pending_o = pending_q;

endmodule

// File: rtl/jam_cost_seq.sv
// Sums the Cost ROM over each offered permutation and reports the run minimum.
// Optional JAM_SEQ_EARLY_ABORT_EN abandons a permutation once it exceeds the min.
module jam_cost_seq #(
    parameter int N      = jam_pkg::N,
    parameter int COST_W = jam_pkg::COST_W,
    parameter int SUM_W  = jam_pkg::SUM_W
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     perm_valid,
    output logic                     perm_ready,
    input  logic [3*N-1:0]           perm_data,
    input  logic                     perm_last,
    output logic [2:0]               W,
    output logic [2:0]               J,
    input  logic [COST_W-1:0]        Cost,
    output logic [SUM_W-1:0]         MinCost,
    output logic [3:0]               MatchCount,
    output logic                     Valid,
    output logic                     busy,
    output jam_pkg::jam_state_e      dbg_state
);
    import jam_pkg::*;

    jam_state_e       state_q;
    logic [IDX_W-1:0] k_q;
    logic [IDX_W-1:0] k_nxt;
    logic [3*N-1:0]   perm_q;
    logic             last_q;
    logic [SUM_W-1:0] acc_q;
    logic [SUM_W-1:0] partial;
    logic [IDX_W-1:0] w_q;
    logic [IDX_W-1:0] j_q;
    logic             valid_q;
    logic             xfer;
    logic             abort;
    logic [SUM_W-1:0] trk_min;
    logic [CNT_W-1:0] trk_cnt;
    logic             trk_pending;

    // Handshake: a permutation transfers on a rising edge where perm_valid and
    // perm_ready are both high; perm_ready is high only in IDLE out of reset.
    assign perm_ready = (state_q == IDLE) && RST;
    assign xfer       = perm_valid && perm_ready;
    assign k_nxt      = k_q + IDX_W'(1);
    assign partial    = acc_q + SUM_W'(Cost);

`ifdef JAM_SEQ_EARLY_ABORT_EN
    assign abort = (state_q == ISSUE) && (k_q != '0) && !trk_pending && (partial > trk_min);
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            k_q     <= '0;
            perm_q  <= '0;
            last_q  <= 1'b0;
            acc_q   <= '0;
            w_q     <= '0;
            j_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        perm_q  <= perm_data;
                        last_q  <= perm_last;
                        acc_q   <= '0;
                        k_q     <= '0;
                        w_q     <= '0;
                        j_q     <= perm_data[IDX_W-1:0];
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    // ROM data arrives one cycle late, so slot k adds address k-1.
                    if (k_q != '0) acc_q <= partial;
                    if (abort) begin
                        state_q <= UPDATE;
                    end else if (k_q == IDX_W'(N-1)) begin
                        state_q <= DRAIN;
                    end else begin
                        k_q <= k_nxt;
                        w_q <= k_nxt;
                        j_q <= job_of(perm_q, k_nxt);
                    end
                end
                DRAIN: begin
                    acc_q   <= partial;
                    state_q <= UPDATE;
                end
                UPDATE: begin
                    if (last_q) begin
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    jam_min_tracker u_tracker (
        .clk_i          (CLK),
        .rst_ni         (RST),
        .update_i       (state_q == UPDATE),
        .last_i         (last_q),
        .sum_i          (acc_q),
        .min_o          (trk_min),
        .count_o        (trk_cnt),
        .init_pending_o (trk_pending)
    );

    assign W          = w_q;
    assign J          = j_q;
    assign MinCost    = trk_min;
    assign MatchCount = trk_cnt;
    assign Valid      = valid_q;
    assign busy       = (state_q != IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_jam_cost_seq.sv
// Bench for jam_cost_seq: a registered ROM model answers W/J, and each run's
// MinCost/MatchCount is predicted from plain permutation sums.
module tb_jam_cost_seq;
    import jam_pkg::*;

    logic                CLK = 1'b0;
    logic                RST = 1'b0;
    logic                perm_valid = 1'b0;
    logic                perm_ready;
    logic [23:0]         perm_data = '0;
    logic                perm_last = 1'b0;
    logic [2:0]          W;
    logic [2:0]          J;
    logic [6:0]          Cost = '0;
    logic [9:0]          MinCost;
    logic [3:0]          MatchCount;
    logic                Valid;
    logic                busy;
    jam_state_e          dbg_state;

    logic [6:0]  rom [8][8];
    logic [23:0] run_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          valid_cnt = 0;
    int          last_max_w = 0;

    jam_cost_seq dut (
        .CLK        (CLK),
        .RST        (RST),
        .perm_valid (perm_valid),
        .perm_ready (perm_ready),
        .perm_data  (perm_data),
        .perm_last  (perm_last),
        .W          (W),
        .J          (J),
        .Cost       (Cost),
        .MinCost    (MinCost),
        .MatchCount (MatchCount),
        .Valid      (Valid),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // Clock/reset-independent infrastructure: clock, ROM with one-cycle latency, monitors.
    always #5 CLK = ~CLK;
    always @(posedge CLK) Cost <= rom[W][J];
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (Valid) valid_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_rom(input int rnd);
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < 8; j++)
                rom[k][j] = rnd ? 7'($urandom_range(0, 127)) : 7'd0;
    endtask

    function automatic int perm_sum(input logic [23:0] p);
        int s = 0;
        for (int k = 0; k < 8; k++) s += int'(rom[k][p[3*k +: 3]]);
        return s;
    endfunction

    task automatic send_perm(input logic [23:0] p, input logic last, output int t_x);
        int guard = 0;
        perm_valid = 1'b1;
        perm_data  = p;
        perm_last  = last;
        while (!perm_ready && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 200) begin
            check("xfer_timeout", 0, 1);
            perm_valid = 1'b0;
            t_x = cyc;
            return;
        end
        @(negedge CLK);
        t_x = cyc;
        perm_valid = 1'b0;
        perm_data  = 24'($urandom);
        perm_last  = 1'($urandom_range(0, 1));
        check("busy_after_xfer", busy, 1);
        check("ready_after_xfer", perm_ready, 0);
    endtask

    // Sends every permutation in run_q (last flag on the final one) and checks the result.
    task automatic do_run(input string tag);
        int exp_min = 1023;
        int exp_cnt = 0;
        int s;
        int t_last = 0;
        int guard = 0;
        int v0;
        foreach (run_q[i]) begin
            s = perm_sum(run_q[i]);
            if (s < exp_min) begin
                exp_min = s;
                exp_cnt = 1;
            end else if (s == exp_min && exp_cnt < 15) begin
                exp_cnt++;
            end
        end
        v0 = valid_cnt;
        foreach (run_q[i]) begin
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            send_perm(run_q[i], i == run_q.size() - 1, t_last);
        end
        last_max_w = int'(W);
        while (!Valid && guard < 100) begin
            @(negedge CLK);
            guard++;
            if (busy && int'(W) > last_max_w) last_max_w = int'(W);
        end
        check({tag, "_valid_seen"}, Valid, 1);
        if (Valid) begin
`ifndef JAM_SEQ_EARLY_ABORT_EN
            // Valid is sampled high at the 11th rising edge after the transfer edge.
            check({tag, "_latency"}, cyc + 1 - t_last, 11);
`endif
            check({tag, "_min"}, MinCost, exp_min);
            check({tag, "_count"}, MatchCount, exp_cnt);
        end
        @(negedge CLK);
        check({tag, "_valid_width"}, Valid, 0);
        check({tag, "_pulses"}, valid_cnt - v0, 1);
    endtask

    initial begin
        int t_x;
        int guard;
        logic [23:0] pool [4];

        fill_rom(0);
        repeat (3) @(negedge CLK);
        check("rst_ready_low", perm_ready, 0);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_ready", perm_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", Valid, 0);
        check("rst_min", MinCost, 0);
        check("rst_count", MatchCount, 0);
        check("rst_w", W, 0);
        check("rst_j", J, 0);
        check("rst_state", dbg_state, IDLE);

        // Identity permutation over a diagonal of 5s.
        fill_rom(1);
        for (int k = 0; k < 8; k++) rom[k][k] = 7'd5;
        run_q = '{24'hFAC688};
        do_run("diag");
        check("diag_min_const", MinCost, 40);

        // Only row 0 costs anything, so sums are selected by the worker-0 job.
        fill_rom(0);
        rom[0][1] = 7'd60;
        rom[0][2] = 7'd45;
        run_q = '{24'd1, 24'd2, 24'd2};
        do_run("three");
        check("three_min_const", MinCost, 45);
        check("three_cnt_const", MatchCount, 2);

        fill_rom(0);
        rom[0][3] = 7'd100;
        run_q.delete();
        for (int i = 0; i < 20; i++) run_q.push_back(24'd3);
        do_run("sat");
        check("sat_cnt_const", MatchCount, 15);

        // Reset in the middle of ISSUE, then a fresh single-permutation run.
        fill_rom(0);
        for (int k = 0; k < 8; k++)
            for (int j = 1; j < 8; j++) rom[k][j] = 7'd100;
        rom[0][0] = 7'd30;
        send_perm({8{3'd7}}, 1'b0, t_x);
        guard = 0;
        while (W != 3'd4 && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        check("midrst_reach_k4", W, 4);
        RST = 1'b0;
        @(negedge CLK);
        check("midrst_ready", perm_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_w", W, 0);
        check("midrst_j", J, 0);
        check("midrst_min", MinCost, 0);
        check("midrst_count", MatchCount, 0);
        RST = 1'b1;
        @(negedge CLK);
        run_q = '{24'd0};
        do_run("postrst");
        check("postrst_min_const", MinCost, 30);
        check("postrst_cnt_const", MatchCount, 1);

        // Back-to-back runs: the second must not inherit the first run's minimum.
        fill_rom(0);
        rom[0][5] = 7'd50;
        rom[0][6] = 7'd70;
        run_q = '{24'd5, 24'd6};
        do_run("runA");
        run_q = '{24'd6, 24'd6};
        do_run("runB");
        check("runB_min_const", MinCost, 70);
        check("runB_cnt_const", MatchCount, 2);

`ifdef JAM_SEQ_EARLY_ABORT_EN
        fill_rom(0);
        rom[0][0] = 7'd20;
        for (int k = 0; k < 7; k++) rom[k][1] = 7'd127;
        rom[7][1] = 7'd11;
        run_q = '{24'd0, {8{3'd1}}};
        do_run("abort");
        check("abort_early_exit", last_max_w < 7, 1);
        check("abort_min_const", MinCost, 20);
        check("abort_cnt_const", MatchCount, 1);
`endif

        // Random ROM contents; permutations drawn from a small pool to provoke ties.
        for (int r = 0; r < 12; r++) begin
            fill_rom(1);
            for (int p = 0; p < 4; p++) pool[p] = 24'($urandom);
            run_q.delete();
            repeat ($urandom_range(1, 6)) run_q.push_back(pool[$urandom_range(0, 3)]);
            do_run("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "bench timeout");
    end

endmodule
